// File: rtl/datamem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arb_pkg
// Purpose  : Shared constants for the datamemory two-port arbiter: the
//            sequencer state encoding and the requester port identifiers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package datamem_arb_pkg;

    // Sequencer states
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    // Requester identifiers
    localparam logic c_PORT_CPU = 1'b0;
    localparam logic c_PORT_DBG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/datamem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arb_pick
// Purpose  : Combinational winner selection between the CPU port (0) and the
//            debug/loader port (1).
//            DATAMEM_ARB_ROUND_ROBIN_EN defined : a tie goes to the port that
//                                                  was not granted last.
//            DATAMEM_ARB_ROUND_ROBIN_EN undefined: port 0 always wins a tie.
// Ports    : req0, req1   - pending requests
//            last         - most recently granted port (round-robin only)
//            grant_valid  - at least one request is pending
//            grant_id     - port that wins this cycle
// Revision : 1.0 - initial release
// ============================================================================
module datamem_arb_pick
    import datamem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = req0 | req1;

`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_id = c_PORT_CPU;
        if (req0 && req1) begin
            grant_id = ~last;
        end else if (req1) begin
            grant_id = c_PORT_DBG;
        end
    end
`else
    // Fixed priority has no history; the input is kept so both builds share
    // one port list.
    logic w_unused_last;
    assign w_unused_last = last;

    always_comb begin
        grant_id = c_PORT_CPU;
        if (!req0 && req1) begin
            grant_id = c_PORT_DBG;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arbiter
// Purpose  : Shares the single-port datamemory between the CPU load/store
//            path (port 0) and a debug/loader port (port 1). A granted access
//            is driven to memory for exactly one cycle (ISSUE) and completed
//            with a one-cycle ack plus read data in the following cycle.
//            Tie policy is selected by the DATAMEM_ARB_ROUND_ROBIN_EN macro.
// Ports    : clk, reset                    - clock, sync active-high reset
//            req*/we*/addr*/wdata*         - held requests from ports 0/1
//            ack*/rdata*                   - completion pulse and read data
//            address/writeData/MemWrite/MemRead - memory command
//            readData                      - memory read data
// Revision : 1.0 - initial release
// ============================================================================
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int ADDRESSWIDTH = 32,
    parameter int WIDTH        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [ADDRESSWIDTH-1:0] addr0,
    input  logic [ADDRESSWIDTH-1:0] addr1,
    input  logic [WIDTH-1:0]        wdata0,
    input  logic [WIDTH-1:0]        wdata1,
    output logic                    ack0,
    output logic                    ack1,
    output logic [WIDTH-1:0]        rdata0,
    output logic [WIDTH-1:0]        rdata1,
    output logic [ADDRESSWIDTH-1:0] address,
    output logic [WIDTH-1:0]        writeData,
    output logic                    MemWrite,
    output logic                    MemRead,
    input  logic [WIDTH-1:0]        readData
);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_owner;
    logic [ADDRESSWIDTH-1:0] r_address;
    logic [WIDTH-1:0]        r_wdata;
    logic                    r_memwrite;
    logic                    r_memread;

    logic                    w_last;
    logic                    w_grant_valid;
    logic                    w_grant_id;
    logic                    w_sel_we;
    logic [ADDRESSWIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0]        w_sel_wdata;
    logic                    w_take;

    // A grant is only taken while idle; requests seen in ISSUE/RESP wait.
    assign w_take = (r_state == c_IDLE) && w_grant_valid;

`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
    logic r_last;

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= c_PORT_DBG;
        end else if (w_take) begin
            r_last <= w_grant_id;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = c_PORT_DBG;
`endif

    datamem_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last        (w_last),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_sel_we    = (w_grant_id == c_PORT_DBG) ? we1    : we0;
    assign w_sel_addr  = (w_grant_id == c_PORT_DBG) ? addr1  : addr0;
    assign w_sel_wdata = (w_grant_id == c_PORT_DBG) ? wdata1 : wdata0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_grant_valid) w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = c_RESP;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Command registers: the enables are live only during ISSUE, while the
    // address and data keep their last values until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= c_PORT_CPU;
            r_address  <= '0;
            r_wdata    <= '0;
            r_memwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (w_take) begin
            r_owner    <= w_grant_id;
            r_address  <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_memwrite <= w_sel_we;
            r_memread  <= ~w_sel_we;
        end else if (r_state == c_ISSUE) begin
            r_memwrite <= 1'b0;
            r_memread  <= 1'b0;
        end
    end

    assign address   = r_address;
    assign writeData = r_wdata;
    assign MemWrite  = r_memwrite;
    assign MemRead   = r_memread;

    // Output logic: ack and read data go only to the owner, in RESP.
    always_comb begin
        ack0   = 1'b0;
        ack1   = 1'b0;
        rdata0 = '0;
        rdata1 = '0;
        if (r_state == c_RESP) begin
            if (r_owner == c_PORT_DBG) begin
                ack1   = 1'b1;
                rdata1 = readData;
            end else begin
                ack0   = 1'b1;
                rdata0 = readData;
            end
        end
    end

endmodule
`default_nettype wire
